// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX pin/checker side and the UART receive frame sequencer.
// master = pin synchronizer and checkers side, slave = uart_rx_ctrl.
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_counter;
  logic                  dat_samp_en;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  frame_err;
  logic                  parity_err;

  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_counter, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, parity_err
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_counter, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, oversample/bit counting, checker strobes, frame verdict.
// Define UART_RX_PARITY_EN to support an optional parity bit; otherwise frames are always 8N1.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_ctrl_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for start edge, counters held at 0
  // START  | start bit, strt_chk_en on last edge
  // DATA   | data bits 1..8, deser_en on last edge of each
  // PARITY | parity bit, par_chk_en on last edge
  // STOP   | stop bit, stp_chk_en on last edge, verdict pulse follows in IDLE
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [3:0]            bit_q, bit_d;
  logic                  samp_q, samp_d;
  logic                  strt_q, strt_d;
  logic                  deser_q, deser_d;
  logic                  stp_q, stp_d;
  logic                  dv_q, dv_d;
  logic                  fe_q, fe_d;
  logic                  last, last_d, ps_legal;
`ifdef UART_RX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  flag_q, flag_d;
  logic                  par_chk_q, par_chk_d;
  logic                  perr_q, perr_d;
`else
  logic                  unused_par_in;
  assign unused_par_in = bus.PAR_EN ^ bus.par_err;
`endif

  assign last     = (edge_q == ps_q - ONE);
  assign ps_legal = (bus.Prescale == PRESCALE_W'(8)) || (bus.Prescale == PRESCALE_W'(16)) ||
                    (bus.Prescale == PRESCALE_W'(32));

  always_comb begin
    state_d = state_q;
    edge_d  = last ? '0 : edge_q + ONE;
    bit_d   = bit_q;
    ps_d    = ps_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d = par_en_q;
    flag_d   = flag_q;
    perr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = 4'd0;
`ifdef UART_RX_PARITY_EN
        flag_d = 1'b0;
`endif
        if (!bus.RX_IN && ps_legal) begin
          state_d = START;
          ps_d    = bus.Prescale;
`ifdef UART_RX_PARITY_EN
          par_en_d = bus.PAR_EN;
`endif
        end
      end
      START: if (last) begin
        if (bus.strt_glitch) begin
          state_d = IDLE;
          fe_d    = 1'b1;
        end else begin
          state_d = DATA;
          bit_d   = 4'd1;
        end
      end
      DATA: if (last) begin
        if (bit_q == 4'd8) begin
          bit_d = 4'd9;
`ifdef UART_RX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (last) begin
        flag_d  = flag_q | bus.par_err;
        state_d = STOP;
        bit_d   = 4'd10;
      end
`endif
      STOP: if (last) begin
        state_d = IDLE;
        bit_d   = 4'd0;
        if (bus.stp_err) fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        else if (flag_q) perr_d = 1'b1;
`endif
        else dv_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = 4'd0;
      end
    endcase

    // Strobes are registered, so decode them from next-cycle state/count to align with edge_cnt.
    last_d  = (edge_d == ps_d - ONE);
    samp_d  = (state_d != IDLE);
    strt_d  = (state_d == START) && last_d;
    deser_d = (state_d == DATA) && last_d;
    stp_d   = (state_d == STOP) && last_d;
`ifdef UART_RX_PARITY_EN
    par_chk_d = (state_d == PARITY) && last_d;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      ps_q    <= '0;
      bit_q   <= 4'd0;
      samp_q  <= 1'b0;
      strt_q  <= 1'b0;
      deser_q <= 1'b0;
      stp_q   <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q  <= 1'b0;
      flag_q    <= 1'b0;
      par_chk_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      ps_q    <= ps_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      strt_q  <= strt_d;
      deser_q <= deser_d;
      stp_q   <= stp_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_en_q  <= par_en_d;
      flag_q    <= flag_d;
      par_chk_q <= par_chk_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.edge_cnt    = edge_q;
  assign bus.bit_counter = bit_q;
  assign bus.dat_samp_en = samp_q;
  assign bus.deser_en    = deser_q;
  assign bus.strt_chk_en = strt_q;
  assign bus.stp_chk_en  = stp_q;
  assign bus.data_valid  = dv_q;
  assign bus.frame_err   = fe_q;
`ifdef UART_RX_PARITY_EN
  assign bus.par_chk_en  = par_chk_q;
  assign bus.parity_err  = perr_q;
`else
  assign bus.par_chk_en  = 1'b0;
  assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl; expectations follow UART_RX_PARITY_EN if defined.
module tb_uart_rx_ctrl;
  localparam int PW = 6;
`ifdef UART_RX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_samp, n_deser, n_strt, n_par, n_stp, mid_res, stp_bit, quiet;
  bit   deser_ok;
  logic dv, fe, pe;

  uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus ();
  uart_rx_ctrl #(.PRESCALE_W(PW)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    bus.RX_IN = 1'b0;
    step();
  endtask

  // Follows one frame from its first non-IDLE cycle to the verdict cycle.
  task automatic watch(input int ps, input int low, input int chg);
    int k;
    int last_k;
    k = 0; last_k = -1;
    n_samp = 0; n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0; mid_res = 0;
    stp_bit = -1; deser_ok = 1'b1;
    while (bus.dat_samp_en === 1'b1 && k < 1000) begin
      n_samp++;
      if (bus.deser_en === 1'b1) begin
        n_deser++;
        if (int'(bus.bit_counter) != n_deser || int'(bus.edge_cnt) != ps - 1) deser_ok = 1'b0;
        if (last_k >= 0 && k - last_k != ps) deser_ok = 1'b0;
        last_k = k;
      end
      if (bus.strt_chk_en === 1'b1) n_strt++;
      if (bus.par_chk_en === 1'b1) n_par++;
      if (bus.stp_chk_en === 1'b1) begin
        n_stp++;
        stp_bit = int'(bus.bit_counter);
      end
      if (bus.data_valid === 1'b1 || bus.frame_err === 1'b1 || bus.parity_err === 1'b1) mid_res++;
      if (k == low - 1) bus.RX_IN = 1'b1;
      if (k == chg) bus.Prescale = 6'd32;
      step();
      k++;
    end
    dv = bus.data_valid;
    fe = bus.frame_err;
    pe = bus.parity_err;
  endtask

  task automatic count_quiet(input int cycles, input bit toggle);
    quiet = 0;
    for (int i = 0; i < cycles; i++) begin
      if (toggle) bus.RX_IN = i[0];
      step();
      if (bus.dat_samp_en === 1'b1 || bus.deser_en === 1'b1 || bus.strt_chk_en === 1'b1 ||
          bus.par_chk_en === 1'b1 || bus.stp_chk_en === 1'b1 || bus.data_valid === 1'b1 ||
          bus.frame_err === 1'b1 || bus.parity_err === 1'b1) quiet++;
    end
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.Prescale = 6'd8;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    step(); step(); step();
    chk("reset_outputs", {bus.dat_samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
        bus.stp_chk_en, bus.data_valid, bus.frame_err, bus.parity_err}, 0);
    chk("reset_counters", {bus.edge_cnt, bus.bit_counter}, 0);
    rst = 1'b0;
    step(); step();

    // Prescale 8, no parity, clean frame
    start_frame();
    watch(8, 1, -1);
    chk("p8_frame_len", n_samp, 80);
    chk("p8_deser_cnt", n_deser, 8);
    chk("p8_deser_seq", deser_ok, 1);
    chk("p8_strt_cnt", n_strt, 1);
    chk("p8_stp_cnt", n_stp, 1);
    chk("p8_stp_bit", stp_bit, 9);
    chk("p8_par_cnt", n_par, 0);
    chk("p8_mid_result", mid_res, 0);
    chk("p8_verdict", {dv, fe, pe}, 3'b100);
    chk("p8_idle_cnt", {bus.edge_cnt, bus.bit_counter}, 0);
    step(); step();

    // Prescale 16 with parity requested and a parity error
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b1; bus.par_err = 1'b1;
    start_frame();
    watch(16, 1, -1);
    chk("p16_frame_len", n_samp, (10 + PE) * 16);
    chk("p16_deser_seq", deser_ok, 1);
    chk("p16_deser_cnt", n_deser, 8);
    chk("p16_par_cnt", n_par, PE);
    chk("p16_stp_bit", stp_bit, 9 + PE);
    chk("p16_mid_result", mid_res, 0);
    chk("p16_verdict", {dv, fe, pe}, (PE == 1) ? 3'b001 : 3'b100);
    bus.PAR_EN = 1'b0; bus.par_err = 1'b0; bus.Prescale = 6'd8;
    step(); step();

    // Start glitch: line low for two cycles, checker flags glitch
    bus.strt_glitch = 1'b1;
    start_frame();
    watch(8, 2, -1);
    chk("glitch_len", n_samp, 8);
    chk("glitch_deser", n_deser, 0);
    chk("glitch_strt", n_strt, 1);
    chk("glitch_verdict", {dv, fe, pe}, 3'b010);
    bus.strt_glitch = 1'b0;
    step(); step();

    // Stop error, then a back-to-back frame started in the verdict cycle
    bus.stp_err = 1'b1;
    start_frame();
    watch(8, 1, -1);
    chk("stperr_len", n_samp, 80);
    chk("stperr_verdict", {dv, fe, pe}, 3'b010);
    bus.stp_err = 1'b0;
    start_frame();
    watch(8, 1, -1);
    chk("b2b_len", n_samp, 80);
    chk("b2b_verdict", {dv, fe, pe}, 3'b100);
    step(); step();

    // Reset in the middle of DATA at bit 5
    start_frame();
    bus.RX_IN = 1'b1;
    for (int i = 0; i < 200 && bus.bit_counter !== 4'd5; i++) step();
    chk("rst_reach_bit5", bus.bit_counter, 5);
    rst = 1'b1;
    step();
    chk("rst_mid_outputs", {bus.dat_samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
        bus.stp_chk_en, bus.data_valid, bus.frame_err, bus.parity_err}, 0);
    chk("rst_mid_counters", {bus.edge_cnt, bus.bit_counter}, 0);
    rst = 1'b0;
    count_quiet(100, 1'b0);
    chk("rst_no_report", quiet, 0);

    // Illegal prescale values ignore line activity
    bus.Prescale = 6'd12;
    count_quiet(40, 1'b1);
    chk("ps12_idle", quiet, 0);
    bus.Prescale = 6'd0;
    count_quiet(40, 1'b1);
    chk("ps0_idle", quiet, 0);
    bus.Prescale = 6'd8;
    step();

    // Prescale changed 8 -> 32 mid-frame takes effect on the next frame only
    start_frame();
    watch(8, 1, 20);
    chk("pschg_len", n_samp, 80);
    chk("pschg_deser_seq", deser_ok, 1);
    chk("pschg_verdict", {dv, fe, pe}, 3'b100);
    step();
    start_frame();
    watch(32, 1, -1);
    chk("p32_len", n_samp, 320);
    chk("p32_deser_seq", deser_ok, 1);
    chk("p32_verdict", {dv, fe, pe}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
